pipe_ctrl: RTL and testbench

- Hazard and sequencing controller for the RV32 5-stage core.
- Watches decode register-read addresses, the ex-stage writeback/load/jump info and the data-bus handshake.
- Drives hold (stall) and flush signals to pc_reg, if_id and id_ex, and forwards the redirect PC.
- Multi-cycle states cover load-use bubbles, post-jump flush windows and bus waits with timeout.

---
 rtl/pipe_ctrl_pkg.sv | 37 +++
 rtl/pipe_ctrl_hazard_detect.sv | 23 ++
 rtl/pipe_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipe_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl_pkg : shared constants and controller state encoding             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

`ifndef ZERO_REG
`define ZERO_REG 5'h0
`endif
`ifndef ZERO_WORD
`define ZERO_WORD 32'h0
`endif
`ifndef HOLD_ENABLE
`define HOLD_ENABLE 1'b1
`endif
`ifndef HOLD_DISABLE
`define HOLD_DISABLE 1'b0
`endif

package pipe_ctrl_pkg;

    localparam logic [4:0]  C_ZERO_REG     = `ZERO_REG;
    localparam logic [31:0] C_ZERO_WORD    = `ZERO_WORD;
    localparam logic        C_HOLD_ENABLE  = `HOLD_ENABLE;
    localparam logic        C_HOLD_DISABLE = `HOLD_DISABLE;
    localparam int          C_CNT_W        = 8;

    typedef enum logic [1:0] {
        CTRL_RUN      = 2'd0,
        CTRL_LU_STALL = 2'd1,
        CTRL_FLUSH    = 2'd2,
        CTRL_BUS_WAIT = 2'd3
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hazard_detect : load-use comparator between ex-stage rd and decode rs1/rs2 |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_reg1_raddr_i,
    input  logic [4:0] id_reg2_raddr_i,
    input  logic       ex_reg_we_i,
    input  logic [4:0] ex_reg_waddr_i,
    input  logic       ex_is_load_i,
    output logic       hit_o
);

    assign hit_o = ex_is_load_i && ex_reg_we_i && (ex_reg_waddr_i != C_ZERO_REG) &&
                   ((ex_reg_waddr_i == id_reg1_raddr_i) || (ex_reg_waddr_i == id_reg2_raddr_i));

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_ctrl : hazard/sequencing controller (load-use, jump flush, bus wait)  |
// | Optional macro PIPE_CTRL_PERF_EN adds stall/flush performance counters.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int BUS_TIMEOUT  = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_reg1_raddr_i,
    input  logic [4:0]  id_reg2_raddr_i,
    input  logic        ex_reg_we_i,
    input  logic [4:0]  ex_reg_waddr_i,
    input  logic        ex_is_load_i,
    input  logic        ex_jump_flag_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        bus_req_i,
    input  logic        bus_ack_i,
    output logic        hold_pc_o,
    output logic        hold_if_id_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        hold_all_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        bus_err_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o,
    output logic [31:0] perf_flush_cnt_o
`endif
);

    localparam logic [C_CNT_W-1:0] C_FLUSH_LOAD = C_CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_TIMEOUT    = C_CNT_W'(BUS_TIMEOUT);

    ctrl_state_t        r_state, w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic               r_pend, w_pend_nxt;
    logic [31:0]        r_pend_addr, w_pend_addr_nxt;
    logic               w_lu_hit;
    logic [31:0]        w_jump_tgt;

    hazard_detect u_hazard_detect (
        .id_reg1_raddr_i (id_reg1_raddr_i),
        .id_reg2_raddr_i (id_reg2_raddr_i),
        .ex_reg_we_i     (ex_reg_we_i),
        .ex_reg_waddr_i  (ex_reg_waddr_i),
        .ex_is_load_i    (ex_is_load_i),
        .hit_o           (w_lu_hit)
    );

    // A jump deferred by a bus wait takes precedence over whatever is in ex now.
    assign w_jump_tgt = r_pend ? r_pend_addr : ex_jump_addr_i;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_pend_nxt      = r_pend;
        w_pend_addr_nxt = r_pend_addr;
        hold_pc_o       = C_HOLD_DISABLE;
        hold_if_id_o    = C_HOLD_DISABLE;
        hold_all_o      = C_HOLD_DISABLE;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        jump_flag_o     = 1'b0;
        jump_addr_o     = C_ZERO_WORD;
        bus_err_o       = 1'b0;

        case (r_state)
            CTRL_RUN: begin
                if (bus_req_i && !bus_ack_i) begin
                    hold_all_o  = C_HOLD_ENABLE;
                    w_state_nxt = CTRL_BUS_WAIT;
                    w_cnt_nxt   = '0;
                    if (ex_jump_flag_i && !r_pend) begin
                        w_pend_nxt      = 1'b1;
                        w_pend_addr_nxt = ex_jump_addr_i;
                    end
                end else if (ex_jump_flag_i || r_pend) begin
                    jump_flag_o   = 1'b1;
                    jump_addr_o   = w_jump_tgt;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                    w_pend_nxt    = 1'b0;
                    if (FLUSH_CYCLES > 1) begin
                        w_state_nxt = CTRL_FLUSH;
                        w_cnt_nxt   = C_FLUSH_LOAD;
                    end
                end else if (w_lu_hit) begin
                    hold_pc_o     = C_HOLD_ENABLE;
                    hold_if_id_o  = C_HOLD_ENABLE;
                    flush_id_ex_o = 1'b1;
                    w_state_nxt   = CTRL_LU_STALL;
                end
            end
            CTRL_LU_STALL: begin
                w_state_nxt = CTRL_RUN;
            end
            CTRL_FLUSH: begin
                // r_cnt counts the FLUSH-state cycles still owed, this one included.
                flush_if_id_o = 1'b1;
                flush_id_ex_o = 1'b1;
                if (ex_jump_flag_i) begin
                    jump_flag_o = 1'b1;
                    jump_addr_o = ex_jump_addr_i;
                    w_cnt_nxt   = C_FLUSH_LOAD;
                end else if (r_cnt <= C_CNT_W'(1)) begin
                    w_state_nxt = CTRL_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - C_CNT_W'(1);
                end
            end
            CTRL_BUS_WAIT: begin
                hold_all_o = C_HOLD_ENABLE;
                if (ex_jump_flag_i && !r_pend) begin
                    w_pend_nxt      = 1'b1;
                    w_pend_addr_nxt = ex_jump_addr_i;
                end
                if (bus_ack_i) begin
                    w_state_nxt = CTRL_RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt >= C_TIMEOUT) begin
                    bus_err_o   = 1'b1;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = CTRL_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = CTRL_RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        // Outputs must drop the moment reset asserts, not at the next edge.
        if (!rst) begin
            hold_pc_o     = C_HOLD_DISABLE;
            hold_if_id_o  = C_HOLD_DISABLE;
            hold_all_o    = C_HOLD_DISABLE;
            flush_if_id_o = 1'b0;
            flush_id_ex_o = 1'b0;
            jump_flag_o   = 1'b0;
            jump_addr_o   = C_ZERO_WORD;
            bus_err_o     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= CTRL_RUN;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= C_ZERO_WORD;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_addr <= w_pend_addr_nxt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if ((hold_pc_o || hold_all_o) && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
            if (flush_id_ex_o && (r_perf_flush != 32'hFFFF_FFFF)) begin
                r_perf_flush <= r_perf_flush + 32'd1;
            end
        end
    end

    assign perf_stall_cnt_o = r_perf_stall;
    assign perf_flush_cnt_o = r_perf_flush;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// Scoreboard bench for pipe_ctrl (FLUSH_CYCLES=2, BUS_TIMEOUT=8): the driver
// queues the hand-computed output vector per cycle; a negedge monitor compares.

module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  id_reg1_raddr;
    logic [4:0]  id_reg2_raddr;
    logic        ex_reg_we;
    logic [4:0]  ex_reg_waddr;
    logic        ex_is_load;
    logic        ex_jump_flag;
    logic [31:0] ex_jump_addr;
    logic        bus_req;
    logic        bus_ack;
    logic        hold_pc;
    logic        hold_if_id;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        hold_all;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        bus_err;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .FLUSH_CYCLES (2),
        .BUS_TIMEOUT  (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_reg1_raddr_i (id_reg1_raddr),
        .id_reg2_raddr_i (id_reg2_raddr),
        .ex_reg_we_i     (ex_reg_we),
        .ex_reg_waddr_i  (ex_reg_waddr),
        .ex_is_load_i    (ex_is_load),
        .ex_jump_flag_i  (ex_jump_flag),
        .ex_jump_addr_i  (ex_jump_addr),
        .bus_req_i       (bus_req),
        .bus_ack_i       (bus_ack),
        .hold_pc_o       (hold_pc),
        .hold_if_id_o    (hold_if_id),
        .flush_if_id_o   (flush_if_id),
        .flush_id_ex_o   (flush_id_ex),
        .hold_all_o      (hold_all),
        .jump_flag_o     (jump_flag),
        .jump_addr_o     (jump_addr),
        .bus_err_o       (bus_err)
    );

    // {hold_pc, hold_if_id, flush_if_id, flush_id_ex, hold_all, jump_flag, bus_err, jump_addr}
    logic [38:0] act;
    assign act = {hold_pc, hold_if_id, flush_if_id, flush_id_ex, hold_all, jump_flag, bus_err, jump_addr};

    logic [38:0] exp_q[$];
    string       name_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic        stim_done = 1'b0;
    logic        drained   = 1'b0;

    always @(negedge clk) begin
        logic [38:0] e;
        string       n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
        if (stim_done && exp_q.size() == 0) drained = 1'b1;
    end

    function automatic logic [38:0] ev(input logic hp, input logic hi, input logic fi,
                                       input logic fe, input logic ha, input logic jf,
                                       input logic be, input logic [31:0] a);
        return {hp, hi, fi, fe, ha, jf, be, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        id_reg1_raddr = 5'd0;
        id_reg2_raddr = 5'd0;
        ex_reg_we     = 1'b0;
        ex_reg_waddr  = 5'd0;
        ex_is_load    = 1'b0;
        ex_jump_flag  = 1'b0;
        ex_jump_addr  = 32'h0;
        bus_req       = 1'b0;
        bus_ack       = 1'b0;
    endtask

    task automatic expect_out(input logic [38:0] e, input string n);
        exp_q.push_back(e);
        name_q.push_back(n);
    endtask

    task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        ex_is_load    = 1'b1;
        ex_reg_we     = 1'b1;
        ex_reg_waddr  = rd;
        id_reg1_raddr = rs1;
        id_reg2_raddr = rs2;
    endtask

    logic [38:0] z_v, lu_v, fl_v, ha_v;

    initial begin
        z_v  = ev(0, 0, 0, 0, 0, 0, 0, 32'h0);
        lu_v = ev(1, 1, 0, 1, 0, 0, 0, 32'h0);
        fl_v = ev(0, 0, 1, 1, 0, 0, 0, 32'h0);
        ha_v = ev(0, 0, 0, 0, 1, 0, 0, 32'h0);

        // Reset held: outputs forced low even with a jump request present
        tick(); expect_out(z_v, "reset_idle");
        tick(); ex_jump_flag = 1'b1; ex_jump_addr = 32'h55; expect_out(z_v, "reset_gates_jump");
        tick(); rst = 1'b1; expect_out(z_v, "run_after_reset");

        // Load-use on rs1, single bubble, then rs2
        tick(); set_load(5'd5, 5'd5, 5'd0); expect_out(lu_v, "lu_rs1_hit");
        tick(); set_load(5'd5, 5'd5, 5'd0); expect_out(z_v, "lu_stall_cycle");
        tick(); expect_out(z_v, "lu_done");
        tick(); set_load(5'd7, 5'd1, 5'd7); expect_out(lu_v, "lu_rs2_hit");
        tick(); expect_out(z_v, "lu_stall_cycle2");
        tick(); set_load(5'd0, 5'd0, 5'd0); expect_out(z_v, "lu_zero_reg");
        tick(); set_load(5'd9, 5'd9, 5'd0); ex_is_load = 1'b0; expect_out(z_v, "not_load");

        // Jump with 2-cycle flush window
        tick(); ex_jump_flag = 1'b1; ex_jump_addr = 32'h100;
        expect_out(ev(0, 0, 1, 1, 0, 1, 0, 32'h100), "jump_redirect");
        tick(); expect_out(fl_v, "jump_flush2");
        tick(); expect_out(z_v, "jump_done");

        // Jump and load-use together: jump wins, load-use ignored in FLUSH
        tick(); ex_jump_flag = 1'b1; ex_jump_addr = 32'h140; set_load(5'd3, 5'd3, 5'd0);
        expect_out(ev(0, 0, 1, 1, 0, 1, 0, 32'h140), "jump_over_lu");
        tick(); set_load(5'd3, 5'd3, 5'd0); expect_out(fl_v, "flush_ignores_lu");
        tick(); expect_out(z_v, "jump_lu_done");

        // New jump inside FLUSH restarts the window
        tick(); ex_jump_flag = 1'b1; ex_jump_addr = 32'h180;
        expect_out(ev(0, 0, 1, 1, 0, 1, 0, 32'h180), "jump_a");
        tick(); ex_jump_flag = 1'b1; ex_jump_addr = 32'h1c0;
        expect_out(ev(0, 0, 1, 1, 0, 1, 0, 32'h1c0), "flush_rejump");
        tick(); expect_out(fl_v, "rejump_flush2");
        tick(); expect_out(z_v, "rejump_done");

        // Bus access acked in the request cycle never stalls
        tick(); bus_req = 1'b1; bus_ack = 1'b1; expect_out(z_v, "bus_immediate_ack");

        // Bus wait: 4 hold cycles, pending jump applied after ack
        tick(); bus_req = 1'b1; expect_out(ha_v, "bus_req");
        tick(); bus_req = 1'b1; expect_out(ha_v, "bus_wait1");
        tick(); bus_req = 1'b1; ex_jump_flag = 1'b1; ex_jump_addr = 32'h200;
        expect_out(ha_v, "bus_wait_jump_latched");
        tick(); bus_req = 1'b1; bus_ack = 1'b1; expect_out(ha_v, "bus_ack");
        tick(); expect_out(ev(0, 0, 1, 1, 0, 1, 0, 32'h200), "pending_jump_applied");
        tick(); expect_out(fl_v, "pending_flush2");
        tick(); expect_out(z_v, "pending_done");

        // Timeout after 8 wait cycles, pending jump dropped
        tick(); bus_req = 1'b1; expect_out(ha_v, "to_req");
        for (int i = 0; i < 8; i++) begin
            tick(); bus_req = 1'b1;
            if (i == 2) begin
                ex_jump_flag = 1'b1;
                ex_jump_addr = 32'h300;
            end
            expect_out(ha_v, "to_wait");
        end
        tick(); expect_out(ev(0, 0, 0, 0, 1, 0, 1, 32'h0), "to_bus_err");
        tick(); expect_out(z_v, "to_pending_dropped");
        tick(); expect_out(z_v, "to_err_one_cycle");

        // Ack coinciding with timeout: no error
        tick(); bus_req = 1'b1; expect_out(ha_v, "aw_req");
        for (int i = 0; i < 8; i++) begin
            tick(); bus_req = 1'b1; expect_out(ha_v, "aw_wait");
        end
        tick(); bus_ack = 1'b1; expect_out(ha_v, "ack_wins");
        tick(); expect_out(z_v, "ack_wins_after");

        // Asynchronous reset in the middle of FLUSH
        tick(); ex_jump_flag = 1'b1; ex_jump_addr = 32'h400;
        expect_out(ev(0, 0, 1, 1, 0, 1, 0, 32'h400), "pre_reset_jump");
        tick(); rst = 1'b0; expect_out(z_v, "reset_in_flush");
        tick(); rst = 1'b1; expect_out(z_v, "reset_release");
        tick(); expect_out(z_v, "no_residual_flush");

        stim_done = 1'b1;
        for (int i = 0; i < 20 && !drained; i++) @(posedge clk);
        if (!drained) begin
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
